// File: rtl/pipeline_ctrl.sv
// Hazard, forwarding and memory-freeze controller for the 5-stage RV32I pipeline.
// Define PERF_CNT_EN to add the stall_cnt/flush_cnt performance counters.
module pipeline_ctrl #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned MEM_TIMEOUT    = 64
`ifdef PERF_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH      = 32
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1_D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2_D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1_E,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2_E,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_E,
    input  logic                      Load_E,
    input  logic                      PCSrc_E,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_M,
    input  logic                      RegWrite_M,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_W,
    input  logic                      RegWrite_W,
    input  logic                      dmem_req_M,
    input  logic                      dmem_ready,
    input  logic                      imem_ready,
    output logic                      Stall_F,
    output logic                      Stall_D,
    output logic                      Stall_E,
    output logic                      Stall_M,
    output logic                      Stall_W,
    output logic                      Flush_D,
    output logic                      Flush_E,
    output logic [1:0]                ForwardA_E,
    output logic [1:0]                ForwardB_E,
    output logic                      mem_err
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
`endif
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_err_q, mem_err_d;
    logic                load_use;
    logic                run_rules;

    always_comb begin
        load_use = Load_E && (Rd_E != '0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
    end

    // Next state and same-cycle stall/flush control.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        run_rules  = 1'b0;
        Stall_F    = 1'b0;
        Stall_D    = 1'b0;
        Stall_E    = 1'b0;
        Stall_M    = 1'b0;
        Stall_W    = 1'b0;
        Flush_D    = 1'b0;
        Flush_E    = 1'b0;

        unique case (state_q)
            BOOT: begin
                Flush_D = 1'b1;
                Flush_E = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                wait_cnt_d = '0;
                if (dmem_req_M && !dmem_ready) begin
                    {Stall_F, Stall_D, Stall_E, Stall_M, Stall_W} = 5'b11111;
                    wait_cnt_d = WAIT_W'(1);
                    state_d    = MEM_WAIT;
                end else begin
                    run_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    {Stall_F, Stall_D, Stall_E, Stall_M, Stall_W} = 5'b11111;
                    // Counter holds the frozen-cycle count including this one; stops at the limit.
                    if ((32'(wait_cnt_q) + 32'd1) >= MEM_TIMEOUT) begin
                        wait_cnt_d = WAIT_W'(MEM_TIMEOUT);
                        mem_err_d  = 1'b1;
                        state_d    = HALT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end else begin
                    run_rules  = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = RUN;
                end
            end
            HALT: begin
                {Stall_F, Stall_D, Stall_E, Stall_M, Stall_W} = 5'b11111;
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (run_rules) begin
            if (PCSrc_E) begin
                Flush_D = 1'b1;
                Flush_E = 1'b1;
            end else if (load_use) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Flush_E = 1'b1;
            end else if (!imem_ready) begin
                Stall_F = 1'b1;
                Flush_D = 1'b1;
            end
        end
    end

    // Operand forwarding; the younger result in M wins over W.
    always_comb begin
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        if (RegWrite_M && (Rd_M != '0) && (Rd_M == Rs1_E)) begin
            ForwardA_E = 2'b10;
        end else if (RegWrite_W && (Rd_W != '0) && (Rd_W == Rs1_E)) begin
            ForwardA_E = 2'b01;
        end
        if (RegWrite_M && (Rd_M != '0) && (Rd_M == Rs2_E)) begin
            ForwardB_E = 2'b10;
        end else if (RegWrite_W && (Rd_W != '0) && (Rd_W == Rs2_E)) begin
            ForwardB_E = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

`ifdef PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic                 branch_fire;

    // Saturating counters; a branch counts only when it wins the RUN priority.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        branch_fire = run_rules && PCSrc_E;
        if (Stall_F && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if (branch_fire && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (MEM_TIMEOUT overridden to 8).
module tb_pipeline_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned TO = 8;

    localparam logic [6:0] C_IDLE = 7'b00000_00;
    localparam logic [6:0] C_BOOT = 7'b00000_11;
    localparam logic [6:0] C_FRZ  = 7'b11111_00;
    localparam logic [6:0] C_LU   = 7'b11000_01;
    localparam logic [6:0] C_BR   = 7'b00000_11;
    localparam logic [6:0] C_IM   = 7'b10000_10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic          Load_E, PCSrc_E, RegWrite_M, RegWrite_W;
    logic          dmem_req_M, dmem_ready, imem_ready;
    logic          Stall_F, Stall_D, Stall_E, Stall_M, Stall_W, Flush_D, Flush_E;
    logic [1:0]    ForwardA_E, ForwardB_E;
    logic          mem_err;
`ifdef PERF_CNT_EN
    logic [31:0]   stall_cnt, flush_cnt;
`endif

    logic [6:0]    ctl;
    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;
    int unsigned   exp_stall = 0;
    int unsigned   exp_flush = 0;

    assign ctl = {Stall_F, Stall_D, Stall_E, Stall_M, Stall_W, Flush_D, Flush_E};

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .REG_ADDR_WIDTH(AW),
        .MEM_TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Rs1_D      (Rs1_D),
        .Rs2_D      (Rs2_D),
        .Rs1_E      (Rs1_E),
        .Rs2_E      (Rs2_E),
        .Rd_E       (Rd_E),
        .Load_E     (Load_E),
        .PCSrc_E    (PCSrc_E),
        .Rd_M       (Rd_M),
        .RegWrite_M (RegWrite_M),
        .Rd_W       (Rd_W),
        .RegWrite_W (RegWrite_W),
        .dmem_req_M (dmem_req_M),
        .dmem_ready (dmem_ready),
        .imem_ready (imem_ready),
        .Stall_F    (Stall_F),
        .Stall_D    (Stall_D),
        .Stall_E    (Stall_E),
        .Stall_M    (Stall_M),
        .Stall_W    (Stall_W),
        .Flush_D    (Flush_D),
        .Flush_E    (Flush_E),
        .ForwardA_E (ForwardA_E),
        .ForwardB_E (ForwardB_E),
        .mem_err    (mem_err)
`ifdef PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        Rs1_D = '0; Rs2_D = '0; Rs1_E = '0; Rs2_E = '0;
        Rd_E = '0; Rd_M = '0; Rd_W = '0;
        Load_E = 1'b0; PCSrc_E = 1'b0; RegWrite_M = 1'b0; RegWrite_W = 1'b0;
        dmem_req_M = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks this cycle's controls, then books its effect on the counter model.
    task automatic cycle(input string tag, input logic [6:0] exp_ctl, input logic exp_br);
        #2;
        chk(tag, 32'(ctl), 32'(exp_ctl));
`ifdef PERF_CNT_EN
        chk({tag, "_scnt"}, stall_cnt, exp_stall);
        chk({tag, "_fcnt"}, flush_cnt, exp_flush);
`endif
        if (exp_ctl[6]) exp_stall++;
        if (exp_br) exp_flush++;
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        #2;
        chk("rst_ctl", 32'(ctl), 32'(C_BOOT));
        chk("rst_err", 32'(mem_err), 32'd0);
        #10;
        rst_n = 1'b1;
        #1;
        chk("boot_ctl", 32'(ctl), 32'(C_BOOT));

        tick();
        cycle("run_idle", C_IDLE, 1'b0);
        chk("run_err", 32'(mem_err), 32'd0);
        chk("run_fwda", 32'(ForwardA_E), 32'd0);

        tick();
        Load_E = 1'b1; Rd_E = 5'd5; Rs1_D = 5'd5; Rs2_D = 5'd3;
        cycle("lu_rs1", C_LU, 1'b0);

        tick();
        Load_E = 1'b0; Rd_E = '0; Rd_M = 5'd5; RegWrite_M = 1'b1;
        cycle("lu_bubble", C_IDLE, 1'b0);

        tick();
        RegWrite_M = 1'b0; Rd_M = '0; Rd_W = 5'd5; RegWrite_W = 1'b1;
        Rs1_E = 5'd5; Rs1_D = '0; Rs2_D = '0;
        cycle("lu_after", C_IDLE, 1'b0);
        chk("lu_fwda_w", 32'(ForwardA_E), 32'd1);
        chk("lu_fwdb", 32'(ForwardB_E), 32'd0);

        tick();
        set_idle();
        Load_E = 1'b1; Rd_E = 5'd9; Rs2_D = 5'd9;
        cycle("lu_rs2", C_LU, 1'b0);

        tick();
        Rd_E = '0; Rs1_D = '0; Rs2_D = '0;
        cycle("lu_x0", C_IDLE, 1'b0);

        tick();
        Load_E = 1'b1; Rd_E = 5'd5; Rs1_D = 5'd5; PCSrc_E = 1'b1; imem_ready = 1'b0;
        cycle("br_lu", C_BR, 1'b1);

        tick();
        set_idle();
        imem_ready = 1'b0;
        cycle("imem", C_IM, 1'b0);

        tick();
        Load_E = 1'b1; Rd_E = 5'd4; Rs1_D = 5'd4;
        cycle("lu_imem", C_LU, 1'b0);

        tick();
        set_idle();
        dmem_req_M = 1'b1; dmem_ready = 1'b0;
        cycle("dw0", C_FRZ, 1'b0);
        tick();
        cycle("dw1", C_FRZ, 1'b0);
        tick();
        cycle("dw2", C_FRZ, 1'b0);
        tick();
        dmem_ready = 1'b1;
        cycle("dw_rel", C_IDLE, 1'b0);
        tick();
        dmem_req_M = 1'b0;
        cycle("dw_run", C_IDLE, 1'b0);

        tick();
        dmem_req_M = 1'b1; dmem_ready = 1'b0;
        cycle("dwb0", C_FRZ, 1'b0);
        tick();
        dmem_ready = 1'b1; PCSrc_E = 1'b1;
        cycle("dwb_rel_br", C_BR, 1'b1);
        tick();
        set_idle();
        cycle("dwb_run", C_IDLE, 1'b0);

        tick();
        RegWrite_M = 1'b1; Rd_M = 5'd7; RegWrite_W = 1'b1; Rd_W = 5'd7; Rs2_E = 5'd7;
        cycle("fwd_mw", C_IDLE, 1'b0);
        chk("fwdb_m_pri", 32'(ForwardB_E), 32'd2);
        chk("fwda_none", 32'(ForwardA_E), 32'd0);
        tick();
        RegWrite_M = 1'b0;
        cycle("fwd_w", C_IDLE, 1'b0);
        chk("fwdb_w", 32'(ForwardB_E), 32'd1);
        tick();
        RegWrite_M = 1'b1; Rd_M = '0; RegWrite_W = 1'b1; Rd_W = '0; Rs1_E = '0; Rs2_E = '0;
        cycle("fwd_x0", C_IDLE, 1'b0);
        chk("fwda_x0", 32'(ForwardA_E), 32'd0);
        chk("fwdb_x0", 32'(ForwardB_E), 32'd0);
        tick();
        Rd_M = 5'd3; Rs1_E = 5'd3; Rs2_E = 5'd3; RegWrite_W = 1'b0;
        cycle("fwd_m", C_IDLE, 1'b0);
        chk("fwda_m", 32'(ForwardA_E), 32'd2);
        chk("fwdb_m", 32'(ForwardB_E), 32'd2);

        tick();
        set_idle();
        dmem_req_M = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < int'(TO); i++) begin
            cycle("to_wait", C_FRZ, 1'b0);
            chk("to_err_lo", 32'(mem_err), 32'd0);
            tick();
        end
        cycle("halt", C_FRZ, 1'b0);
        chk("halt_err", 32'(mem_err), 32'd1);
        tick();
        dmem_ready = 1'b1; dmem_req_M = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("halt_hold", C_FRZ, 1'b0);
            chk("halt_err_hold", 32'(mem_err), 32'd1);
            tick();
        end

        rst_n = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        #1;
        chk("rst_halt_ctl", 32'(ctl), 32'(C_BOOT));
        chk("rst_halt_err", 32'(mem_err), 32'd0);
`ifdef PERF_CNT_EN
        chk("rst_scnt", stall_cnt, 32'd0);
        chk("rst_fcnt", flush_cnt, 32'd0);
`endif
        #3;
        rst_n = 1'b1;
        #2;
        chk("reboot_ctl", 32'(ctl), 32'(C_BOOT));
        tick();
        cycle("post_rst", C_IDLE, 1'b0);
        chk("post_rst_err", 32'(mem_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the 5-stage RV32I pipeline. Each cycle it drives the stall and flush enables of the F/D, D/E, E/M and M/W pipeline registers, and selects the operand-forwarding muxes in Execute. It also holds the whole pipeline frozen while a data-memory access is pending, and traps a hung data memory with a sticky error.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5: register-index width.
- MEM_TIMEOUT, 64: maximum consecutive frozen cycles in MEM_WAIT before the block declares a fault.
- CNT_WIDTH, 32: performance-counter width (PERF_CNT_EN only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- Rs1_D, Rs2_D  in  REG_ADDR_WIDTH  source registers in Decode.
- Rs1_E, Rs2_E  in  REG_ADDR_WIDTH  source registers in Execute.
- Rd_E  in  REG_ADDR_WIDTH  destination register in Execute.
- Load_E  in  1  instruction in Execute is a load.
- PCSrc_E  in  1  taken branch or jump resolved in Execute.
- Rd_M, RegWrite_M  in  5/1  Memory-stage destination and write enable.
- Rd_W, RegWrite_W  in  5/1  Writeback-stage destination and write enable.
- dmem_req_M  in  1  load or store present in Memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- imem_ready  in  1  instruction memory returns a valid word this cycle.
- Stall_F, Stall_D, Stall_E, Stall_M, Stall_W  out  1  hold the PC or the corresponding pipeline register.
- Flush_D, Flush_E  out  1  load a bubble (all-zero) into the F/D or D/E register.
- ForwardA_E, ForwardB_E  out  2  operand select: 00 register file, 10 ALU result from M, 01 result from W.
- mem_err  out  1  sticky data-memory timeout flag.
- stall_cnt, flush_cnt  out  CNT_WIDTH  performance counters (PERF_CNT_EN only).

## Operation
- FSM states: BOOT, RUN, MEM_WAIT, HALT. Reset drives the FSM to BOOT.

BOOT (one cycle):
- Flush_D=1, Flush_E=1, all stalls 0.
- Next state: RUN.

RUN evaluates its rules by priority, highest first:
1. dmem_req_M & !dmem_ready:
   - All five stalls=1, no flush.
   - Wait counter loads 1. Next state: MEM_WAIT.
2. PCSrc_E:
   - Flush_D=1, Flush_E=1, Stall_F=0 so the PC takes the target.
   - Load-use and imem_ready are ignored this cycle.
3. Load-use, i.e. Load_E & Rd_E!=0 & (Rd_E==Rs1_D | Rd_E==Rs2_D):
   - Stall_F=1, Stall_D=1, Flush_E=1.
4. !imem_ready:
   - Stall_F=1, Flush_D=1.

MEM_WAIT:
- While !dmem_ready: all stalls=1 and the wait counter increments.
- If the counter reaches MEM_TIMEOUT: set mem_err, next state HALT.
- On dmem_ready=1: outputs follow RUN rules 2–4 that cycle, next state RUN.

HALT:
- All stalls=1, no flushes.
- Leaves only on reset. mem_err stays 1.

Forwarding (combinational, identical in all states), shown for ForwardA_E; ForwardB_E uses Rs2_E:
- 10 if RegWrite_M & Rd_M!=0 & Rd_M==Rs1_E.
- Else 01 if RegWrite_W & Rd_W!=0 & Rd_W==Rs1_E.
- Else 00.
- M has priority over W.

## Timing
- All stall and flush outputs are combinational from the current state and current inputs, with zero latency, so the pipeline registers act on the same rising edge.
- Reset values: state=BOOT, wait counter=0, mem_err=0, counters=0. During reset Flush_D=Flush_E=1 and all stalls 0.
- Reset asserted mid-MEM_WAIT or in HALT returns to BOOT immediately (asynchronous).
- Load-use costs exactly one bubble. A branch costs two bubbles.
- A wait of N cycles (N < MEM_TIMEOUT) freezes the pipeline for exactly N cycles.
- The wait counter is at least clog2(MEM_TIMEOUT+1) bits wide and never wraps.

## Configuration
- PERF_CNT_EN defined: stall_cnt increments on every cycle with Stall_F=1; flush_cnt increments on every cycle where rule 2 fires. Both saturate at all-ones and clear on reset.
- PERF_CNT_EN undefined: the counter ports and their logic are absent. All other behaviour is unchanged.

## Test plan
- Reset release: one BOOT cycle with Flush_D=Flush_E=1, then RUN with all outputs 0 and mem_err=0.
- Load x5 into Execute with Rs1_D=5: exactly one cycle of Stall_F=Stall_D=Flush_E=1. The next cycle shows ForwardA_E=01 once the load reaches W.
- Same load-use as above plus PCSrc_E=1 in the same cycle: Flush_D=Flush_E=1, Stall_F=0, and no stall.
- dmem_req_M=1 with dmem_ready low for 3 cycles: all stalls=1 for 3 cycles, release on the 4th, and stall_cnt advances by 3.
- dmem_ready held low with MEM_TIMEOUT=8: mem_err rises after 8 wait cycles, the FSM enters HALT, and only rst_n low clears it.
- RegWrite_M and RegWrite_W both target x7 and Rs2_E=7: ForwardB_E=10. Rd_M=0 with RegWrite_M=1 and Rs1_E=0: ForwardA_E=00.
